hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
Parametrised hazard-detection and forwarding controller for the pipelined ARM core. It keeps its own shadow pipeline of in-flight destination registers (EXE, MEM, WB slots), so the pipeline does not have to feed stage registers back. Each cycle it decides whether the instruction in ID must stall. It also produces registered forwarding selects that are valid while that instruction sits in EXE. It sits beside the ID stage and drives PC/IF-ID freeze, ID/EXE bubble insertion and the EXE operand muxes.

Parameters:
REG_W, 4, register-index width (2**REG_W architectural registers)
FWD_EN, 1, 1 = forwarding mode (stall only on load-use or WB-slot conflict); 0 = stall on any RAW match
WB_BYPASS_RF, 1, 1 = register file writes before it is read in the same cycle, so the WB slot is never a hazard; 0 = WB slot is checked
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  global pipeline freeze (memory busy); shadow pipeline and registered outputs hold
flush  in  1  branch taken in EXE; ID instruction is discarded
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_W  Rn index
id_src2  in  REG_W  Rm index
id_use_src1  in  1  Rn is read
id_use_src2  in  1  Rm is read (two-source instruction)
id_dest  in  REG_W  destination index of the ID instruction
id_wb_en  in  1  ID instruction writes id_dest
id_mem_read  in  1  ID instruction is a load
hazard  out  1  combinational stall request: freeze PC and IF/ID, insert bubble into EXE
fwd_sel_a  out  2  registered EXE operand-1 select: 0 = regfile, 1 = MEM-stage ALU result, 2 = WB-stage result
fwd_sel_b  out  2  same for operand 2
stall_count  out  CNT_W  saturating count of cycles with hazard asserted

Behaviour:
- Reset (rst=1 at clk edge): all slots invalid (valid=0, wb_en=0, mem_read=0, dest=0); fwd_sel_a/b=0; stall_count=0. Reset has priority over freeze and flush.
- Slot S (E, M, W) holds valid, dest, wb_en, mem_read.
- match(S, src, use) = id_valid & use & S.valid & S.wb_en & (S.dest == src).
- Raw hazard (before flush masking):
  - FWD_EN=0: any match on E or M for either source. If WB_BYPASS_RF=0, a match on W also counts.
  - FWD_EN=1: any match on E where E.mem_read=1 (load-use). If WB_BYPASS_RF=0, a W match with no E or M match for the same source also counts.
- hazard = raw hazard & ~flush. It is combinational in the same cycle and is not gated by freeze.
- Shadow advance, per clock edge when rst=0 and freeze=0:
  - W<=M; M<=E.
  - E<=bubble (all fields 0) if hazard | flush | ~id_valid; otherwise E<={1, id_dest, id_wb_en, id_mem_read}.
- Forwarding registers, updated on the same edge as the shadow advance:
  - Each source: 1 if match on E, else 2 if match on M, else 0. A match on E takes priority over M (newest producer).
  - Forced to 0 when FWD_EN=0, or when the E slot is loaded with a bubble (hazard, flush or ~id_valid).
- Load-use is resolved in exactly one stall cycle. The load moves to M, and the dependent instruction then receives select 2.
- stall_count increments by 1 on each edge where hazard=1, rst=0 and freeze=0. It saturates at 2**CNT_W-1 with no wrap.
- freeze=1: slots, fwd_sel and stall_count hold. hazard still reflects the current slots and ID inputs.
- flush and hazard in the same cycle: flush wins. hazard=0 and a bubble goes into E.
- Register index 0 is a normal register; there is no hardwired zero.

Test Plan:
- FWD_EN=1: ADD R1 enters E; the next ID instruction reads R1 as Rn -> hazard=0, and after the edge fwd_sel_a=1, fwd_sel_b=0.
- FWD_EN=1: LDR R2 in E, ID reads R2 as Rm with id_use_src2=1 -> hazard=1 for exactly 1 cycle, a bubble enters E, then fwd_sel_b=2 and stall_count=1.
- Producers to R3 in both E and M, ID reads R3 on both sources -> fwd_sel_a=fwd_sel_b=1 (E wins).
- FWD_EN=0: write R4 in M, ID reads R4 -> hazard=1. Hold the ID inputs: hazard=1 on the next cycle only if WB_BYPASS_RF=0, otherwise 0.
- LDR R5 in E, dependent in ID, flush=1 -> hazard=0, E becomes a bubble, fwd_sel=0 and stall_count unchanged.
- Load-use with freeze=1 for 3 cycles -> hazard stays 1, slots and stall_count hold. Then assert rst mid-stall -> every slot invalid, hazard=0, stall_count=0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding controller for the pipelined ARM core.
// Tracks in-flight destinations in a private EXE/MEM/WB shadow pipeline.
module hazard_forward_unit #(
  parameter int REG_W        = 4,
  parameter bit FWD_EN       = 1'b1,
  parameter bit WB_BYPASS_RF = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  output logic             hazard,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  slot_t e_slot, m_slot, w_slot;

  function automatic logic match(input slot_t s, input logic [REG_W-1:0] src,
                                 input logic used);
    return id_valid & used & s.valid & s.wb_en & (s.dest == src);
  endfunction

  logic e1, m1, w1, e2, m2, w2;
  assign e1 = match(e_slot, id_src1, id_use_src1);
  assign m1 = match(m_slot, id_src1, id_use_src1);
  assign w1 = match(w_slot, id_src1, id_use_src1);
  assign e2 = match(e_slot, id_src2, id_use_src2);
  assign m2 = match(m_slot, id_src2, id_use_src2);
  assign w2 = match(w_slot, id_src2, id_use_src2);

  logic raw_hazard;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    raw_hazard = 1'b0;
    if (!FWD_EN) begin
      raw_hazard = e1 | e2 | m1 | m2;
      if (!WB_BYPASS_RF) raw_hazard = raw_hazard | w1 | w2;
    end else begin
      raw_hazard = e_slot.mem_read & (e1 | e2);
      // A WB producer only matters when no newer producer can be forwarded instead.
      if (!WB_BYPASS_RF)
        raw_hazard = raw_hazard | (w1 & ~e1 & ~m1) | (w2 & ~e2 & ~m2);
    end
  end

  assign hazard = raw_hazard & ~flush;

  logic       bubble;
  logic [1:0] sel_a_next, sel_b_next;

  assign bubble = hazard | flush | ~id_valid;

  // The E-slot producer will be in MEM when the consumer reaches EXE, hence select 1.
  always_comb begin
    sel_a_next = SEL_RF;
    sel_b_next = SEL_RF;
    if (FWD_EN && !bubble) begin
      sel_a_next = e1 ? SEL_MEM : (m1 ? SEL_WB : SEL_RF);
      sel_b_next = e2 ? SEL_MEM : (m2 ? SEL_WB : SEL_RF);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_slot      <= BUBBLE;
      m_slot      <= BUBBLE;
      w_slot      <= BUBBLE;
      fwd_sel_a   <= SEL_RF;
      fwd_sel_b   <= SEL_RF;
      stall_count <= '0;
    end else if (!freeze) begin
      w_slot    <= m_slot;
      m_slot    <= e_slot;
      e_slot    <= bubble ? BUBBLE : '{valid: 1'b1, dest: id_dest,
                                       wb_en: id_wb_en, mem_read: id_mem_read};
      fwd_sel_a <= sel_a_next;
      fwd_sel_b <= sel_b_next;
      if (hazard && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule
